// File: rtl/fizzbuzz_seq.sv
// fizzbuzz_seq: frame-paced FizzBuzz counter that renders eight 4-bit char codes
// for a VGA text renderer. The count advances every FRAMES_PER_STEP newframes.
// Optional build macro FIZZBUZZ_SEQ_PAUSE_EN enables the pause/step HOLD mode;
// without it, pause and step are ignored and HOLD is never entered.
module fizzbuzz_seq #(
    parameter int unsigned FRAMES_PER_STEP = 30,
    parameter int unsigned MAX_COUNT       = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        newframe,
    input  logic        pause,
    input  logic        step,
    output logic [31:0] line,
    output logic [11:0] count_bcd,
    output logic        tick,
    output logic        paused
);

    localparam int unsigned FCNT_W = 8;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [11:0] MAX_BCD = {4'(MAX_COUNT / 100),
                                       4'((MAX_COUNT / 10) % 10),
                                       4'(MAX_COUNT % 10)};

    localparam logic [3:0] C_B     = 4'd10;
    localparam logic [3:0] C_F     = 4'd11;
    localparam logic [3:0] C_I     = 4'd12;
    localparam logic [3:0] C_U     = 4'd13;
    localparam logic [3:0] C_Z     = 4'd14;
    localparam logic [3:0] C_BLANK = 4'd15;
    localparam logic [31:0] LINE_RESET = 32'hFFFF_F1FF;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t            state;
    logic [FCNT_W-1:0] fcnt;
    logic [1:0]        mod3;
    logic [2:0]        mod5;
    logic              pending;

    logic              hold_req;
    logic              step_req;
    logic [31:0]       render_c;
    logic [11:0]       count_inc_c;
    logic [1:0]        mod3_inc_c;
    logic [2:0]        mod5_inc_c;
    logic              adv_c;

`ifdef FIZZBUZZ_SEQ_PAUSE_EN
    assign hold_req = pause;
    assign step_req = step;
`else
    logic unused_inputs;
    assign unused_inputs = pause ^ step;
    assign hold_req      = 1'b0;
    assign step_req      = 1'b0;
`endif

    // Render the current count into eight char codes (char0 in the low nibble)
    always_comb begin
        logic [3:0] hund_c;
        logic [3:0] tens_c;
        hund_c = (count_bcd[11:8] == 4'd0) ? C_BLANK : count_bcd[11:8];
        tens_c = (count_bcd[11:4] == 8'd0) ? C_BLANK : count_bcd[7:4];
        if (mod3 == 2'd0 && mod5 == 3'd0) begin
            render_c = {C_Z, C_Z, C_U, C_B, C_Z, C_Z, C_I, C_F};
        end else if (mod3 == 2'd0) begin
            render_c = {{4{C_BLANK}}, C_Z, C_Z, C_I, C_F};
        end else if (mod5 == 3'd0) begin
            render_c = {{4{C_BLANK}}, C_Z, C_Z, C_U, C_B};
        end else begin
            render_c = {{5{C_BLANK}}, count_bcd[3:0], tens_c, hund_c};
        end
    end

    // Next count in BCD and its residues, wrapping from MAX_COUNT back to 1
    always_comb begin
        count_inc_c = count_bcd;
        mod3_inc_c  = (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
        mod5_inc_c  = (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
        if (count_bcd == MAX_BCD) begin
            count_inc_c = 12'h001;
            mod3_inc_c  = 2'd1;
            mod5_inc_c  = 3'd1;
        end else if (count_bcd[3:0] != 4'd9) begin
            count_inc_c[3:0] = count_bcd[3:0] + 4'd1;
        end else begin
            count_inc_c[3:0] = 4'd0;
            if (count_bcd[7:4] != 4'd9) begin
                count_inc_c[7:4] = count_bcd[7:4] + 4'd1;
            end else begin
                count_inc_c[7:4]  = 4'd0;
                count_inc_c[11:8] = count_bcd[11:8] + 4'd1;
            end
        end
    end

    // Advance fires on newframe: frame budget exhausted in RUN, or a pending step in HOLD
    always_comb begin
        adv_c = newframe && (((state == S_RUN) && (fcnt == FCNT_LAST)) ||
                             ((state == S_HOLD) && pending));
    end

    // Control FSM, frame counter, count/residue registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            fcnt      <= '0;
            count_bcd <= 12'h001;
            mod3      <= 2'd1;
            mod5      <= 3'd1;
            pending   <= 1'b0;
            line      <= LINE_RESET;
            tick      <= 1'b0;
            paused    <= 1'b0;
        end else begin
            tick <= adv_c;
            if (newframe) begin
                line <= render_c;
            end
            if (adv_c) begin
                count_bcd <= count_inc_c;
                mod3      <= mod3_inc_c;
                mod5      <= mod5_inc_c;
            end
            case (state)
                S_INIT: begin
                    state   <= S_RUN;
                    paused  <= 1'b0;
                    pending <= 1'b0;
                end
                S_RUN: begin
                    pending <= 1'b0;
                    if (newframe) begin
                        fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + FCNT_W'(1);
                    end
                    if (hold_req) begin
                        state  <= S_HOLD;
                        paused <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (newframe && pending) begin
                        pending <= step_req;
                    end else if (step_req) begin
                        pending <= 1'b1;
                    end
                    if (!hold_req) begin
                        state  <= S_RUN;
                        paused <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_INIT;
                    paused <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fizzbuzz_seq.sv
// tb_fizzbuzz_seq: directed self-checking bench for fizzbuzz_seq.
// Instance u1 runs with FRAMES_PER_STEP=1, instance u4 with FRAMES_PER_STEP=4.
// Pause/step checks follow FIZZBUZZ_SEQ_PAUSE_EN.
module tb_fizzbuzz_seq;

    logic        clk;
    logic        rst;
    logic        nf1, pause1, step1;
    logic [31:0] line1;
    logic [11:0] cnt1;
    logic        tick1, paused1;
    logic        nf4, pause4, step4;
    logic [31:0] line4;
    logic [11:0] cnt4;
    logic        tick4, paused4;

    int total = 0;
    int bad   = 0;

    fizzbuzz_seq #(.FRAMES_PER_STEP(1), .MAX_COUNT(100)) u1 (
        .clk(clk), .rst(rst), .newframe(nf1), .pause(pause1), .step(step1),
        .line(line1), .count_bcd(cnt1), .tick(tick1), .paused(paused1)
    );

    fizzbuzz_seq #(.FRAMES_PER_STEP(4), .MAX_COUNT(100)) u4 (
        .clk(clk), .rst(rst), .newframe(nf4), .pause(pause4), .step(step4),
        .line(line4), .count_bcd(cnt4), .tick(tick4), .paused(paused4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nf1_pulse();
        nf1 = 1'b1;
        cyc();
        nf1 = 1'b0;
    endtask

    task automatic advance_to(input logic [11:0] target);
        int n;
        n = 0;
        while (cnt1 !== target && n < 300) begin
            nf1_pulse();
            cyc();
            n++;
        end
        chk("reach_count", 32'(cnt1), 32'(target));
    endtask

    initial begin
        int         changes;
        logic [31:0] held;
        rst = 1'b1; nf1 = 1'b0; pause1 = 1'b0; step1 = 1'b0;
        nf4 = 1'b0; pause4 = 1'b0; step4 = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_line", line1, 32'hFFFF_F1FF);
        chk("rst_count", 32'(cnt1), 32'h001);
        chk("rst_tick", 32'(tick1), 32'h0);
        chk("rst_paused", 32'(paused1), 32'h0);
        chk("rst_line4", line4, 32'hFFFF_F1FF);
        cyc();

        // First three frames with one frame per step
        nf1_pulse();
        chk("nf1_line", line1, 32'hFFFF_F1FF);
        chk("nf1_count", 32'(cnt1), 32'h002);
        chk("nf1_tick", 32'(tick1), 32'h1);
        cyc();
        chk("nf1_tick_drop", 32'(tick1), 32'h0);
        nf1_pulse();
        chk("nf2_line", line1, 32'hFFFF_F2FF);
        nf1_pulse();
        chk("nf3_fizz", line1, 32'hFFFF_EECB);
        chk("nf3_count", 32'(cnt1), 32'h004);
        cyc();

        // Buzz, plain digits, FizzBuzz
        advance_to(12'h005);
        nf1_pulse();
        chk("buzz5", line1, 32'hFFFF_EEDA);
        cyc();
        advance_to(12'h007);
        nf1_pulse();
        chk("digit7", line1, 32'hFFFF_F7FF);
        cyc();
        advance_to(12'h015);
        nf1_pulse();
        chk("fizzbuzz15", line1, 32'hEEDA_EECB);
        cyc();
        advance_to(12'h041);
        nf1_pulse();
        chk("digit41", line1, 32'hFFFF_F14F);
        nf1_pulse();
        chk("fizz42", line1, 32'hFFFF_EECB);
        chk("count43", 32'(cnt1), 32'h043);
        cyc();
        advance_to(12'h097);
        nf1_pulse();
        chk("digit97", line1, 32'hFFFF_F79F);
        cyc();

        // Wrap from 100 back to 1 with residues restored
        advance_to(12'h100);
        nf1_pulse();
        chk("buzz100", line1, 32'hFFFF_EEDA);
        chk("wrap_count", 32'(cnt1), 32'h001);
        chk("wrap_tick", 32'(tick1), 32'h1);
        nf1_pulse();
        chk("wrap_line1", line1, 32'hFFFF_F1FF);
        nf1_pulse();
        nf1_pulse();
        chk("wrap_fizz3", line1, 32'hFFFF_EECB);
        nf1_pulse();
        nf1_pulse();
        chk("wrap_buzz5", line1, 32'hFFFF_EEDA);
        cyc();

        // Reset coinciding with newframe at count 57
        advance_to(12'h057);
        nf1 = 1'b1;
        rst = 1'b1;
        cyc();
        nf1 = 1'b0;
        rst = 1'b0;
        chk("midrst_count", 32'(cnt1), 32'h001);
        chk("midrst_line", line1, 32'hFFFF_F1FF);
        chk("midrst_tick", 32'(tick1), 32'h0);
        cyc();

        // Four frames per step, 800-cycle gaps between newframes
        for (int k = 1; k <= 12; k++) begin
            nf4 = 1'b1;
            cyc();
            nf4 = 1'b0;
            chk($sformatf("fps4_tick_k%0d", k), 32'(tick4), (k % 4 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("fps4_line_k%0d", k), line4,
                (k <= 4) ? 32'hFFFF_F1FF : (k <= 8) ? 32'hFFFF_F2FF : 32'hFFFF_EECB);
            chk($sformatf("fps4_count_k%0d", k), 32'(cnt4), 32'(1 + k / 4));
            held    = line4;
            changes = 0;
            for (int g = 0; g < 800; g++) begin
                cyc();
                if (line4 !== held || tick4 !== 1'b0) changes++;
            end
            chk($sformatf("fps4_gap_stable_k%0d", k), 32'(changes), 32'h0);
        end

`ifdef FIZZBUZZ_SEQ_PAUSE_EN
        // HOLD: frozen count, coalesced steps, step with newframe deferred
        nf1_pulse();
        nf1_pulse();
        chk("pre_pause_count", 32'(cnt1), 32'h003);
        pause1 = 1'b1;
        cyc();
        chk("paused_on", 32'(paused1), 32'h1);
        for (int i = 0; i < 3; i++) begin
            nf1_pulse();
            chk("hold_frozen", 32'(cnt1), 32'h003);
            chk("hold_no_tick", 32'(tick1), 32'h0);
        end
        step1 = 1'b1; cyc(); step1 = 1'b0; cyc();
        step1 = 1'b1; cyc(); step1 = 1'b0;
        chk("step_wait_nf", 32'(cnt1), 32'h003);
        nf1_pulse();
        chk("step_adv", 32'(cnt1), 32'h004);
        chk("step_tick", 32'(tick1), 32'h1);
        nf1_pulse();
        chk("step_once", 32'(cnt1), 32'h004);
        step1 = 1'b1; nf1 = 1'b1;
        cyc();
        step1 = 1'b0; nf1 = 1'b0;
        chk("step_nf_same", 32'(cnt1), 32'h004);
        nf1_pulse();
        chk("step_nf_next", 32'(cnt1), 32'h005);
        pause1 = 1'b0;
        cyc();
        chk("paused_off", 32'(paused1), 32'h0);
        nf1_pulse();
        chk("resume_count", 32'(cnt1), 32'h006);
`else
        // Pause and step have no effect in this build
        pause1 = 1'b1;
        step1  = 1'b1;
        cyc();
        chk("nopause_paused", 32'(paused1), 32'h0);
        nf1_pulse();
        chk("nopause_adv", 32'(cnt1), 32'h002);
        chk("nopause_tick", 32'(tick1), 32'h1);
        pause1 = 1'b0;
        step1  = 1'b0;
`endif
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
